div_unit: RTL and testbench



---
 rtl/div_unit.sv | 110 +++++++++++
 tb/tb_div_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Holds the pipeline through div_stall while iterating; div_valid pulses once the result is ready.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] div_a,
  input  logic [XLEN-1:0] div_b,
  output logic            div_stall,
  output logic            div_valid,
  output logic [XLEN-1:0] div_result,
  output logic            div_busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] r_q, q_q, b_q, res_q;
  logic            rem_q, qneg_q, rneg_q;

  logic            is_signed, div_zero, ovf, special, accept, last;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;
  logic [XLEN:0]   sh;
  logic [XLEN+1:0] t;
  logic            ge;
  logic [XLEN-1:0] r_nx, q_nx, fin_q, fin_r;

  // Operand conditioning and special cases, evaluated on the capture cycle
  always_comb begin
    is_signed = ~div_op[0];
    a_mag     = (is_signed && div_a[XLEN-1]) ? -div_a : div_a;
    b_mag     = (is_signed && div_b[XLEN-1]) ? -div_b : div_b;
    div_zero  = (div_b == '0);
    ovf       = is_signed && (div_a == {1'b1, {(XLEN-1){1'b0}}}) && (&div_b);
    special   = div_zero | ovf;
    // overflow quotient equals the dividend (most negative value)
    if (div_zero) spec_res = div_op[1] ? div_a : '1;
    else          spec_res = div_op[1] ? '0 : div_a;
    accept    = (state_q == IDLE) && div_start;
  end

  // One restoring step: the shifted partial remainder can need XLEN+1 bits
  always_comb begin
    sh    = {r_q, q_q[XLEN-1]};
    t     = {1'b0, sh} - {2'b00, b_q};
    ge    = ~t[XLEN+1];
    r_nx  = ge ? t[XLEN-1:0] : sh[XLEN-1:0];
    q_nx  = {q_q[XLEN-2:0], ge};
    last  = (cnt_q == CW'(XLEN - 1));
    fin_q = qneg_q ? -q_nx : q_nx;
    fin_r = rneg_q ? -r_nx : r_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_start) state_d = special ? DONE : BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_stall = accept || (state_q == BUSY);
    div_valid = (state_q == DONE);
    div_busy  = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      rem_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= a_mag;
      b_q    <= b_mag;
      rem_q  <= div_op[1];
      qneg_q <= is_signed && (div_a[XLEN-1] ^ div_b[XLEN-1]);
      rneg_q <= is_signed && div_a[XLEN-1];
      if (special) res_q <= spec_res;
    end else if (state_q == BUSY) begin
      r_q   <= r_nx;
      q_q   <= q_nx;
      cnt_q <= cnt_q + CW'(1);
      if (last) res_q <= rem_q ? fin_r : fin_q;
    end
  end

  assign div_result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus corner sequences,
// with expected results queued at issue and compared when div_valid fires.
module tb_div_unit;

  logic        clk, rst, div_start;
  logic [1:0]  div_op;
  logic [31:0] div_a, div_b;
  logic        div_stall, div_valid, div_busy;
  logic [31:0] div_result;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .div_start(div_start), .div_op(div_op),
    .div_a(div_a), .div_b(div_b), .div_stall(div_stall), .div_valid(div_valid),
    .div_result(div_result), .div_busy(div_busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_valid = -1;
  int          prev_valid = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    cyc++;
    if (div_valid) begin
      prev_valid = last_valid;
      last_valid = cyc;
      if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else chk("result", div_result, sb.pop_front());
      chk("stall_and_valid", {31'd0, div_stall}, 32'd0);
    end
  end

  // Issue one divide in the cycle after the previous DONE, count stall cycles
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_stall);
    int nst;
    @(posedge clk); #1;
    div_start = 1'b1; div_op = op; div_a = a; div_b = b;
    sb.push_back(exp);
    nst = 0;
    @(negedge clk);
    while (div_stall && nst < 100) begin
      nst++;
      @(posedge clk); #1;
      div_start = 1'b0;
      @(negedge clk);
    end
    div_start = 1'b0;
    chk("stall_cycles", nst, exp_stall);
    chk("valid_after_stall", {31'd0, div_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; div_start = 1'b0; div_op = 2'b00; div_a = '0; div_b = '0;

    vecs.push_back('{2'b01, 32'd100,        32'd7,        32'd14,         33});
    vecs.push_back('{2'b11, 32'd100,        32'd7,        32'd2,          33});
    vecs.push_back('{2'b00, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,   33});
    vecs.push_back('{2'b10, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF,   33});
    vecs.push_back('{2'b00, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   33});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFFFFFE, 32'd1,          33});
    vecs.push_back('{2'b01, 32'd5,          32'd0,        32'hFFFFFFFF,   1});
    vecs.push_back('{2'b11, 32'd5,          32'd0,        32'd5,          1});
    vecs.push_back('{2'b00, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   1});
    vecs.push_back('{2'b10, 32'h80000000,   32'hFFFFFFFF, 32'd0,          1});
    vecs.push_back('{2'b00, 32'd5,          32'd0,        32'hFFFFFFFF,   1});
    vecs.push_back('{2'b10, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB,   1});
    vecs.push_back('{2'b01, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,   33});
    vecs.push_back('{2'b11, 32'hFFFFFFFF,   32'd10,       32'd5,          33});
    vecs.push_back('{2'b01, 32'h80000000,   32'hFFFFFFFF, 32'd0,          33});
    vecs.push_back('{2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,         33});
    vecs.push_back('{2'b10, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE,   33});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_stall",  {31'd0, div_stall}, 32'd0);
    chk("rst_valid",  {31'd0, div_valid}, 32'd0);
    chk("rst_busy",   {31'd0, div_busy},  32'd0);
    chk("rst_result", div_result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Table, issued back-to-back with no gap cycle
    foreach (vecs[i]) do_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall);
    @(posedge clk);
    chk("b2b_spacing", last_valid - prev_valid, 32'd34);

    // Inputs toggled while BUSY must not disturb the captured operation
    #1;
    div_start = 1'b1; div_op = 2'b01; div_a = 32'd1000; div_b = 32'd7;
    sb.push_back(32'd142);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      div_start = 1'($urandom_range(0, 1));
      div_op = 2'($urandom_range(0, 3));
      div_a = $urandom; div_b = $urandom;
      @(posedge clk); #1;
    end
    div_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (div_valid) break;
    end
    chk("toggle_valid", {31'd0, div_valid}, 32'd1);

    // Reset at iteration 10 aborts the divide
    @(posedge clk); #1;
    div_start = 1'b1; div_op = 2'b01; div_a = 32'd12345; div_b = 32'd6;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_stall", {31'd0, div_stall}, 32'd0);
    chk("abort_busy",  {31'd0, div_busy},  32'd0);
    chk("abort_valid", {31'd0, div_valid}, 32'd0);
    @(negedge clk);
    chk("abort_busy_hold", {31'd0, div_busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    do_div(2'b01, 32'd9, 32'd3, 32'd3, 33);
    @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
